// File: rtl/alu_exec_unit.sv
// Purpose  : execute stage of the MIPS-style datapath (ALU-control decode, ALU, PC+4, branch target).
// Latency  : exactly 1 cycle from an in_valid capture edge to the registered outputs.
// Backpress: none; a new operation is accepted every cycle in_valid is high, data holds otherwise.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid          capture enable for all inputs below
//   alu_op, funct     ALUop from control and instruction[5:0], decoded to alu_sel
//   op_a, op_b        ALU operands (op_b already muxed between register and immediate)
//   pc, imm16, branch current PC, instruction[15:0], branch control
//   out_valid         high for one cycle after each capture
//   alu_sel, result, zero, pc_plus4, branch_target, branch_taken, next_pc  registered results
//   overflow          signed overflow of add/sub, present only when ALU_OVF_DETECT_EN is defined
//
// Build option: ALU_OVF_DETECT_EN adds the overflow output and its detection logic.

module alu_exec_unit #(
   parameter int DATA_W = 32,
   parameter int PC_INC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [1:0]        alu_op,
   input  logic [5:0]        funct,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [DATA_W-1:0] pc,
   input  logic [15:0]       imm16,
   input  logic              branch,
   output logic              out_valid,
   output logic [3:0]        alu_sel,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic [DATA_W-1:0] pc_plus4,
   output logic [DATA_W-1:0] branch_target,
   output logic              branch_taken,
   output logic [DATA_W-1:0] next_pc
`ifdef ALU_OVF_DETECT_EN
   ,
   output logic              overflow
`endif
);

   // ALU operation encodings
   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_SUB = 4'b0110;
   localparam logic [3:0] SEL_SLT = 4'b0111;
   localparam logic [3:0] SEL_NOR = 4'b1100;
   localparam logic [3:0] SEL_INV = 4'b1111;

   // R-type funct encodings
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);

   logic [3:0]        alu_sel_d;
   logic [DATA_W-1:0] sum_d;
   logic [DATA_W-1:0] diff_d;
   logic              lt_d;
   logic [DATA_W-1:0] result_d;
   logic              zero_d;
   logic [DATA_W-1:0] pc_plus4_d;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] br_offset;
   logic [DATA_W-1:0] branch_target_d;
   logic              branch_taken_d;
   logic [DATA_W-1:0] next_pc_d;

   // ALU-control decode: alu_op selects a fixed op except 10, which defers to funct
   always_comb begin
      alu_sel_d = SEL_INV;
      case (alu_op)
         2'b00: alu_sel_d = SEL_ADD;
         2'b01: alu_sel_d = SEL_SUB;
         2'b11: alu_sel_d = SEL_SLT;
         default: begin
            case (funct)
               FN_ADD:  alu_sel_d = SEL_ADD;
               FN_SUB:  alu_sel_d = SEL_SUB;
               FN_AND:  alu_sel_d = SEL_AND;
               FN_OR:   alu_sel_d = SEL_OR;
               FN_SLT:  alu_sel_d = SEL_SLT;
               FN_NOR:  alu_sel_d = SEL_NOR;
               default: alu_sel_d = SEL_INV;
            endcase
         end
      endcase
   end

   // Add/sub wrap modulo 2^DATA_W; carry out is intentionally dropped
   assign sum_d  = op_a + op_b;
   assign diff_d = op_a - op_b;
   assign lt_d   = ($signed(op_a) < $signed(op_b));

   always_comb begin
      result_d = '0;
      case (alu_sel_d)
         SEL_AND: result_d = op_a & op_b;
         SEL_OR:  result_d = op_a | op_b;
         SEL_ADD: result_d = sum_d;
         SEL_SUB: result_d = diff_d;
         SEL_SLT: result_d = {{(DATA_W-1){1'b0}}, lt_d};
         SEL_NOR: result_d = ~(op_a | op_b);
         default: result_d = '0;   // unknown op reads as zero, so zero flag is set
      endcase
   end

   assign zero_d = (result_d == '0);

   // Sequential PC and branch target; both wrap silently at the top of the address space
   assign pc_plus4_d      = pc + PC_STEP;
   assign imm_sext        = {{(DATA_W-16){imm16[15]}}, imm16};
   assign br_offset       = {imm_sext[DATA_W-3:0], 2'b00};
   assign branch_target_d = pc_plus4_d + br_offset;
   assign branch_taken_d  = branch & zero_d;
   assign next_pc_d       = branch_taken_d ? branch_target_d : pc_plus4_d;

`ifdef ALU_OVF_DETECT_EN
   logic ovf_d;

   // Signed overflow: add when operands agree in sign and the result does not;
   // sub when operands differ in sign and the result sign departs from op_a.
   always_comb begin
      ovf_d = 1'b0;
      case (alu_sel_d)
         SEL_ADD: ovf_d = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                          (sum_d[DATA_W-1] != op_a[DATA_W-1]);
         SEL_SUB: ovf_d = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                          (diff_d[DATA_W-1] != op_a[DATA_W-1]);
         default: ovf_d = 1'b0;
      endcase
   end
`endif

   // Output register: reset wins over capture; data holds while in_valid is low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         alu_sel       <= '0;
         result        <= '0;
         zero          <= 1'b0;
         pc_plus4      <= '0;
         branch_target <= '0;
         branch_taken  <= 1'b0;
         next_pc       <= '0;
`ifdef ALU_OVF_DETECT_EN
         overflow      <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            alu_sel       <= alu_sel_d;
            result        <= result_d;
            zero          <= zero_d;
            pc_plus4      <= pc_plus4_d;
            branch_target <= branch_target_d;
            branch_taken  <= branch_taken_d;
            next_pc       <= next_pc_d;
`ifdef ALU_OVF_DETECT_EN
            overflow      <= ovf_d;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Purpose  : directed self-checking bench for alu_exec_unit.
// Latency  : each vector is applied, then outputs are checked 1 ns after the next rising edge.
// Backpress: none; in_valid is driven directly.

module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] op_a, op_b, pc;
   logic [15:0] imm16;
   logic        branch;
   logic        out_valid;
   logic [3:0]  alu_sel;
   logic [31:0] result, pc_plus4, branch_target, next_pc;
   logic        zero, branch_taken;
`ifdef ALU_OVF_DETECT_EN
   logic        overflow;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.DATA_W(32), .PC_INC(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .alu_op        (alu_op),
      .funct         (funct),
      .op_a          (op_a),
      .op_b          (op_b),
      .pc            (pc),
      .imm16         (imm16),
      .branch        (branch),
      .out_valid     (out_valid),
      .alu_sel       (alu_sel),
      .result        (result),
      .zero          (zero),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target),
      .branch_taken  (branch_taken),
      .next_pc       (next_pc)
`ifdef ALU_OVF_DETECT_EN
      ,
      .overflow      (overflow)
`endif
   );

   // Drive one set of inputs and step past the capturing edge
   task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                        input logic [15:0] imm, input logic br);
      in_valid = v; alu_op = aop; funct = f; op_a = a; op_b = b;
      pc = p; imm16 = imm; branch = br;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(1'b1, 2'b10, 6'b100000, 32'h11, 32'h22, 32'h400, 16'h0001, 1'b1);
      drive(1'b1, 2'b10, 6'b100000, 32'h11, 32'h22, 32'h400, 16'h0001, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", zero); end
      checks++; if (alu_sel !== 4'h0) begin errors++; $display("FAIL reset_alu_sel got=%h exp=0", alu_sel); end
      checks++; if ({pc_plus4, branch_target, next_pc} !== 96'h0) begin errors++;
         $display("FAIL reset_pcs got=%h %h %h exp=0", pc_plus4, branch_target, next_pc); end
      checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", branch_taken); end
`ifdef ALU_OVF_DETECT_EN
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`endif
   endtask

   task automatic test_add;
      rst_n = 1'b1;
      drive(1'b1, 2'b10, 6'b100000, 32'd5, 32'd7, 32'h0, 16'h0000, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
      checks++; if (result !== 32'd12) begin errors++; $display("FAIL add_result got=%h exp=0000000c", result); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got=%b exp=0", zero); end
      checks++; if (alu_sel !== 4'b0010) begin errors++; $display("FAIL add_alu_sel got=%b exp=0010", alu_sel); end
      checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL add_pc_plus4 got=%h exp=00000004", pc_plus4); end
   endtask

   task automatic test_branch;
      // taken, positive offset
      drive(1'b1, 2'b01, 6'b000000, 32'h1234, 32'h1234, 32'h100, 16'h0003, 1'b1);
      checks++; if (alu_sel !== 4'b0110) begin errors++; $display("FAIL br_alu_sel got=%b exp=0110", alu_sel); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL br_zero got=%b exp=1", zero); end
      checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL br_taken got=%b exp=1", branch_taken); end
      checks++; if (branch_target !== 32'h110) begin errors++; $display("FAIL br_target got=%h exp=00000110", branch_target); end
      checks++; if (next_pc !== 32'h110) begin errors++; $display("FAIL br_next_pc got=%h exp=00000110", next_pc); end
      // not taken: result nonzero
      drive(1'b1, 2'b01, 6'b000000, 32'd5, 32'd3, 32'h200, 16'h0010, 1'b1);
      checks++; if (result !== 32'd2) begin errors++; $display("FAIL brn_result got=%h exp=00000002", result); end
      checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL brn_taken got=%b exp=0", branch_taken); end
      checks++; if (branch_target !== 32'h244) begin errors++; $display("FAIL brn_target got=%h exp=00000244", branch_target); end
      checks++; if (next_pc !== 32'h204) begin errors++; $display("FAIL brn_next_pc got=%h exp=00000204", next_pc); end
      // zero but branch control low: no branch
      drive(1'b1, 2'b01, 6'b000000, 32'd9, 32'd9, 32'h300, 16'h0004, 1'b0);
      checks++; if (branch_taken !== 1'b0 || next_pc !== 32'h304) begin errors++;
         $display("FAIL brz_nobranch got=%b/%h exp=0/00000304", branch_taken, next_pc); end
      // negative offset: target = 0x104 - 4
      drive(1'b1, 2'b01, 6'b000000, 32'd7, 32'd7, 32'h100, 16'hFFFF, 1'b1);
      checks++; if (branch_target !== 32'h100) begin errors++; $display("FAIL brneg_target got=%h exp=00000100", branch_target); end
      checks++; if (next_pc !== 32'h100) begin errors++; $display("FAIL brneg_next_pc got=%h exp=00000100", next_pc); end
   endtask

   task automatic test_slt_nor;
      drive(1'b1, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'h0, 16'h0000, 1'b0);
      checks++; if (result !== 32'd1) begin errors++; $display("FAIL slt_result got=%h exp=00000001", result); end
      checks++; if (alu_sel !== 4'b0111) begin errors++; $display("FAIL slt_alu_sel got=%b exp=0111", alu_sel); end
      drive(1'b1, 2'b10, 6'b100111, 32'h0, 32'h0, 32'h0, 16'h0000, 1'b0);
      checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL nor_result got=%h exp=ffffffff", result); end
      checks++; if (alu_sel !== 4'b1100 || zero !== 1'b0) begin errors++;
         $display("FAIL nor_sel_zero got=%b/%b exp=1100/0", alu_sel, zero); end
   endtask

   task automatic test_pc_wrap;
      drive(1'b1, 2'b00, 6'b111111, 32'd1, 32'd2, 32'hFFFFFFFC, 16'h0000, 1'b0);
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got=%h exp=00000000", pc_plus4); end
      checks++; if (next_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc got=%h exp=00000000", next_pc); end
      checks++; if (result !== 32'd3 || alu_sel !== 4'b0010) begin errors++;
         $display("FAIL wrap_aluop00 got=%h/%b exp=00000003/0010", result, alu_sel); end
   endtask

   task automatic test_invalid_funct;
      drive(1'b1, 2'b10, 6'b111111, 32'h55, 32'h66, 32'h40, 16'h0002, 1'b0);
      checks++; if (alu_sel !== 4'b1111) begin errors++; $display("FAIL inv_alu_sel got=%b exp=1111", alu_sel); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL inv_result got=%h exp=00000000", result); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL inv_zero got=%b exp=1", zero); end
   endtask

   task automatic test_back_to_back;
      logic [1:0]  aops [4] = '{2'b10, 2'b10, 2'b11, 2'b10};
      logic [5:0]  fns  [4] = '{6'b100100, 6'b100101, 6'b000000, 6'b100010};
      logic [31:0] as   [4] = '{32'h0000F0F0, 32'h0000F0F0, 32'd3, 32'd5};
      logic [31:0] bs   [4] = '{32'h0000FF00, 32'h0000FF00, 32'hFFFFFFFE, 32'd7};
      logic [31:0] exp_r[4] = '{32'h0000F000, 32'h0000FFF0, 32'h0, 32'hFFFFFFFE};
      logic [3:0]  exp_s[4] = '{4'b0000, 4'b0001, 4'b0111, 4'b0110};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, aops[i], fns[i], as[i], bs[i], 32'h1000 + 32'(i * 4), 16'h0000, 1'b0);
         checks++; if (result !== exp_r[i] || alu_sel !== exp_s[i] || out_valid !== 1'b1) begin errors++;
            $display("FAIL b2b_%0d got=%h/%b/%b exp=%h/%b/1", i, result, alu_sel, out_valid, exp_r[i], exp_s[i]); end
         checks++; if (pc_plus4 !== 32'h1004 + 32'(i * 4)) begin errors++;
            $display("FAIL b2b_pc_%0d got=%h exp=%h", i, pc_plus4, 32'h1004 + 32'(i * 4)); end
      end
   endtask

   task automatic test_hold;
      // last capture was sub 5-7 = FFFFFFFE, pc 0x100C
      drive(1'b0, 2'b10, 6'b100000, 32'd1, 32'd1, 32'h8000, 16'h0000, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_out_valid got=%b exp=0", out_valid); end
      checks++; if (result !== 32'hFFFFFFFE || alu_sel !== 4'b0110) begin errors++;
         $display("FAIL hold_result got=%h/%b exp=fffffffe/0110", result, alu_sel); end
      drive(1'b0, 2'b00, 6'b000000, 32'd0, 32'd0, 32'h9000, 16'h0000, 1'b1);
      checks++; if (pc_plus4 !== 32'h1010 || zero !== 1'b0) begin errors++;
         $display("FAIL hold_pc got=%h/%b exp=00001010/0", pc_plus4, zero); end
   endtask

   task automatic test_reset_override;
      rst_n = 1'b0;
      drive(1'b1, 2'b10, 6'b100101, 32'hAAAA, 32'h5555, 32'h700, 16'h0001, 1'b1);
      checks++; if (out_valid !== 1'b0 || result !== 32'h0 || pc_plus4 !== 32'h0) begin errors++;
         $display("FAIL rst_override got=%b/%h/%h exp=0/0/0", out_valid, result, pc_plus4); end
      rst_n = 1'b1;
      drive(1'b1, 2'b10, 6'b100101, 32'hAAAA, 32'h5555, 32'h700, 16'h0001, 1'b1);
      checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF || pc_plus4 !== 32'h704) begin errors++;
         $display("FAIL rst_first_capture got=%b/%h/%h exp=1/0000ffff/00000704", out_valid, result, pc_plus4); end
   endtask

`ifdef ALU_OVF_DETECT_EN
   task automatic test_overflow;
      drive(1'b1, 2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1, 32'h0, 16'h0000, 1'b0);
      checks++; if (result !== 32'h80000000 || overflow !== 1'b1) begin errors++;
         $display("FAIL ovf_add got=%h/%b exp=80000000/1", result, overflow); end
      drive(1'b1, 2'b01, 6'b000000, 32'h80000000, 32'd1, 32'h0, 16'h0000, 1'b0);
      checks++; if (result !== 32'h7FFFFFFF || overflow !== 1'b1) begin errors++;
         $display("FAIL ovf_sub got=%h/%b exp=7fffffff/1", result, overflow); end
      drive(1'b1, 2'b00, 6'b000000, 32'd1, 32'd1, 32'h0, 16'h0000, 1'b0);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_none got=%b exp=0", overflow); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; funct = '0;
      op_a = '0; op_b = '0; pc = '0; imm16 = '0; branch = 1'b0;
      test_reset();
      test_add();
      test_branch();
      test_slt_nor();
      test_pc_wrap();
      test_invalid_funct();
      test_back_to_back();
      test_hold();
      test_reset_override();
`ifdef ALU_OVF_DETECT_EN
      test_overflow();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
